// File: rtl/led_sequencer.sv
// LED colour sequencer: debounced manual stepping, auto-advance timer
// and a host override load, arbitrated onto one colour register.
module led_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_PERIOD     = 8,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button,
  input  logic       mode_sel,
  input  logic       ovr_valid,
  input  logic [2:0] ovr_colour,
  output logic       ovr_ready,
  output logic [2:0] colour,
  output logic [1:0] state,
  output logic       step
);

  typedef enum logic [1:0] {
    ST_MANUAL = 2'b00,
    ST_AUTO   = 2'b01,
    ST_OVR    = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] TMR_LAST = CNT_W'(AUTO_PERIOD - 1);
  localparam logic [2:0]       COL_RST  = 3'b001;

  state_e           state_q, state_d;
  logic [2:0]       colour_q, colour_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             db_q, db_d;
  logic             step_q, step_d;
  logic             ovr_ready_q, ovr_ready_d;

  logic btn_db;
  logic press;
  logic accept;

  function automatic logic [2:0] next_colour(input logic [2:0] c);
    logic [2:0] n;
    case (c)
      3'b001:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b100;
      3'b100:  n = 3'b101;
      3'b101:  n = 3'b110;
      default: n = 3'b001;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] sanitise(input logic [2:0] c);
    logic [2:0] n;
    if (c == 3'b000 || c == 3'b111)
      n = COL_RST;
    else
      n = c;
    return n;
  endfunction

  always_comb begin
    if (!button)
      cnt_d = '0;
    else if (cnt_q == DB_MAX)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;
  end

  assign btn_db = (cnt_q == DB_MAX);
  assign db_d   = btn_db;
  assign press  = btn_db & ~db_q;
  assign accept = ovr_valid & ovr_ready_q
                & (state_q != ST_OVR);

  always_comb begin
    state_d     = state_q;
    colour_d    = colour_q;
    tmr_d       = tmr_q;
    step_d      = 1'b0;
    ovr_ready_d = ovr_ready_q;
    case (state_q)
      ST_MANUAL: begin
        tmr_d = '0;
        if (accept) begin
          colour_d    = sanitise(ovr_colour);
          state_d     = ST_OVR;
          ovr_ready_d = 1'b0;
        end else begin
          if (press) begin
            colour_d = next_colour(colour_q);
            step_d   = 1'b1;
          end
          if (mode_sel)
            state_d = ST_AUTO;
        end
      end
      ST_AUTO: begin
        if (accept) begin
          colour_d    = sanitise(ovr_colour);
          state_d     = ST_OVR;
          ovr_ready_d = 1'b0;
          tmr_d       = '0;
        end else begin
          if (tmr_q == TMR_LAST) begin
            colour_d = next_colour(colour_q);
            step_d   = 1'b1;
            tmr_d    = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
          // the terminal-count step above still lands on the way out
          if (!mode_sel) begin
            state_d = ST_MANUAL;
            tmr_d   = '0;
          end
        end
      end
      ST_OVR: begin
        tmr_d = '0;
        if (!ovr_valid) begin
          state_d     = mode_sel ? ST_AUTO : ST_MANUAL;
          ovr_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_MANUAL;
        colour_d    = COL_RST;
        tmr_d       = '0;
        ovr_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_MANUAL;
      colour_q    <= COL_RST;
      cnt_q       <= '0;
      tmr_q       <= '0;
      db_q        <= 1'b0;
      step_q      <= 1'b0;
      ovr_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      colour_q    <= colour_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      db_q        <= db_d;
      step_q      <= step_d;
      ovr_ready_q <= ovr_ready_d;
    end
  end

  assign colour    = colour_q;
  assign state     = state_q;
  assign step      = step_q;
  assign ovr_ready = ovr_ready_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer: debounce, auto timing,
// override arbitration and reset behaviour.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic       mode_sel;
  logic       ovr_valid;
  logic [2:0] ovr_colour;
  logic       ovr_ready;
  logic [2:0] colour;
  logic [1:0] state;
  logic       step;

  int errs = 0;
  int n    = 0;

  logic [2:0] exp_seq [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                              3'd5, 3'd6, 3'd1, 3'd2};

  led_sequencer #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_PERIOD(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .mode_sel(mode_sel),
    .ovr_valid(ovr_valid),
    .ovr_colour(ovr_colour),
    .ovr_ready(ovr_ready),
    .colour(colour),
    .state(state),
    .step(step)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    button     = 1'b0;
    mode_sel   = 1'b0;
    ovr_valid  = 1'b0;
    ovr_colour = 3'd0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_colour", int'(colour), 1);
    chk("rst_state", int'(state), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_ready", int'(ovr_ready), 1);

    // long press: one step, 5 cycles after button rises
    button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("press_step", int'(step), (i == 5) ? 1 : 0);
      chk("press_colour", int'(colour), (i >= 5) ? 2 : 1);
    end
    button = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rel_step", int'(step), 0);
      chk("rel_colour", int'(colour), 2);
    end

    // glitchy button never reaches the debounce count
    do_reset();
    begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      for (int i = 7; i >= 0; i--) begin
        button = pat[i];
        tick();
        chk("glitch_step", int'(step), 0);
        chk("glitch_colour", int'(colour), 1);
      end
    end
    button = 1'b0;

    // AUTO from reset, step every 8 cycles after entry
    do_reset();
    mode_sel = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      chk("auto_state", int'(state), 1);
      chk("auto_step", int'(step),
          (i > 1 && (i - 1) % 8 == 0) ? 1 : 0);
      chk("auto_colour", int'(colour), int'(exp_seq[(i - 1) / 8]));
    end

    // override 111 at terminal count beats the timer step
    do_reset();
    mode_sel = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("pre_ovr_colour", int'(colour), 1);
    ovr_valid  = 1'b1;
    ovr_colour = 3'b111;
    tick();
    chk("ovr_step", int'(step), 0);
    chk("ovr_colour", int'(colour), 1);
    chk("ovr_state", int'(state), 2);
    chk("ovr_ready", int'(ovr_ready), 0);
    ovr_colour = 3'b100;
    tick();
    chk("ovr_hold_colour", int'(colour), 1);
    chk("ovr_hold_state", int'(state), 2);
    ovr_valid = 1'b0;
    tick();
    chk("ovr_exit_state", int'(state), 1);
    chk("ovr_exit_ready", int'(ovr_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("post_ovr_step", int'(step), (i == 8) ? 1 : 0);
      chk("post_ovr_colour", int'(colour), (i == 8) ? 2 : 1);
    end

    // MANUAL override colliding with a press
    do_reset();
    button = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    ovr_valid  = 1'b1;
    ovr_colour = 3'b100;
    tick();
    chk("movr_colour", int'(colour), 4);
    chk("movr_step", int'(step), 0);
    chk("movr_state", int'(state), 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("movr_hold_colour", int'(colour), 4);
    end
    ovr_valid = 1'b0;
    button    = 1'b0;
    tick();
    chk("movr_exit_state", int'(state), 0);
    chk("movr_exit_colour", int'(colour), 4);
    button = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("movr_press_step", int'(step), (i == 5) ? 1 : 0);
      chk("movr_press_colour", int'(colour), (i == 5) ? 5 : 4);
    end
    button = 1'b0;

    // press and mode change together: step first, then AUTO
    do_reset();
    button = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mode_sel = 1'b1;
    tick();
    chk("mix_step", int'(step), 1);
    chk("mix_colour", int'(colour), 2);
    chk("mix_state", int'(state), 1);
    button = 1'b0;

    // reset mid-override with a partial debounce count
    do_reset();
    ovr_valid  = 1'b1;
    ovr_colour = 3'b011;
    tick();
    chk("rovr_state", int'(state), 2);
    chk("rovr_colour", int'(colour), 3);
    button = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("rovr_rst_colour", int'(colour), 1);
    chk("rovr_rst_state", int'(state), 0);
    chk("rovr_rst_ready", int'(ovr_ready), 1);
    chk("rovr_rst_step", int'(step), 0);
    rst       = 1'b0;
    ovr_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("rovr_db_step", int'(step), (i == 5) ? 1 : 0);
      chk("rovr_db_colour", int'(colour), (i == 5) ? 2 : 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, n);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Controller that sequences the dynamic LED colour register from three sources:
  - a debounced push button (manual stepping);
  - a free-running auto-advance timer;
  - a host override load with a valid/ready handshake.
- Sits between the board button/host interface and the LED driver; owns the colour state and arbitrates which source may change it each cycle.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable-high cycles before a press is accepted (minimum 1).
- AUTO_PERIOD, 8: cycles between colour steps in AUTO mode (minimum 2).
- CNT_W, 8: width of the debounce and auto timers; must hold max(DEBOUNCE_CYCLES, AUTO_PERIOD).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- button  in  1  raw push button, already synchronised to clk.
- mode_sel  in  1  0 = MANUAL, 1 = AUTO; sampled every cycle.
- ovr_valid  in  1  host override request.
- ovr_colour  in  3  colour requested by the host.
- ovr_ready  out  1  high when an override can be accepted.
- colour  out  3  current LED colour (registered).
- state  out  2  00 MANUAL, 01 AUTO, 10 OVERRIDE (11 unused).
- step  out  1  one-cycle pulse in the cycle colour has just advanced by sequence.

Behaviour:
- Interface: single clock clk; reset rst is synchronous and active-high.
- Reset values: colour = 3'b001, state = MANUAL, step = 0, ovr_ready = 1; debounce counter, auto timer and edge register all 0.
- Reset has priority over every other input, including mid-override and mid-timer.

Colour sequence:
- 001 -> 010 -> 011 -> 100 -> 101 -> 110 -> 001 (wraps).
- 000 and 111 are illegal; their successor is 001.
- Override values 000 and 111 are loaded as 001.

Debounce:
- Counter increments while button = 1, saturating at DEBOUNCE_CYCLES; clears to 0 on any cycle button = 0.
- btn_db = (counter == DEBOUNCE_CYCLES).
- press = rising edge of btn_db: a single cycle per press, regardless of hold length.
- Debouncer runs in all states. A press outside MANUAL is discarded and is not queued.

MANUAL:
- press -> colour advances at the next edge; step = 1 in that cycle.
- mode_sel = 1 -> AUTO next cycle; auto timer cleared to 0.

AUTO:
- Timer counts 0..AUTO_PERIOD-1.
- When the timer equals AUTO_PERIOD-1: colour advances, step = 1, timer returns to 0.
- First step after entry occurs AUTO_PERIOD cycles after entering.
- mode_sel = 0 -> MANUAL next cycle; timer cleared, no step.

OVERRIDE:
- Handshake: ovr_valid & ovr_ready in MANUAL or AUTO accepts the request.
  - Next edge: colour <= sanitised ovr_colour, state <= OVERRIDE, ovr_ready <= 0, step = 0.
- While in OVERRIDE: colour held, timer held at 0, presses discarded.
- ovr_valid = 0 -> leave next cycle to MANUAL (mode_sel = 0) or AUTO (mode_sel = 1); ovr_ready returns to 1 in the same cycle.
- If ovr_valid stays high, the block remains in OVERRIDE; a new ovr_colour is not reloaded.

Simultaneous events:
- Accepted override beats a press or timer step in the same cycle; the step is suppressed and step = 0.
- A mode_sel change in the same cycle as a press or terminal count: the step in the current state is taken first, then the state changes.

Timing:
- step is high exactly in the cycle where colour shows the new value; it is never high for two consecutive cycles.

Test Plan:
- Reset, button = 1 for 10 cycles, then 0: colour 001 -> 010 exactly once; step pulses once, 5 cycles after button rises (4 debounce + 1 edge); no further change.
- Button glitch 1,1,1,0,1,1,1,0: no step; colour stays 001.
- mode_sel = 1 from reset for 60 cycles: state = 01; steps every 8 cycles through 010,011,100,101,110,001,010; first step 8 cycles after entry.
- In AUTO with timer = 7, assert ovr_valid with ovr_colour = 3'b111: no step; colour = 001; state = 10; ovr_ready = 0. Drop ovr_valid: state returns to 01 and the next step follows 8 cycles later.
- Override colour 3'b100 in MANUAL while pressing the button: colour = 100 and press ignored. Release override: state = 00 and a new press gives 101.
- rst pulsed while in OVERRIDE with a partially counted debounce: next cycle colour = 001, state = 00, ovr_ready = 1, step = 0. A button held across reset needs a full 4 cycles of debounce to register a press.
